ram_store_scheduler: RTL and testbench

Arbitrates byte-wide writes into the shared sensor-data dual-port RAM among multiple word producers: lighthouse sensors, OOTX decoders and wheel counters. Each producer posts a word of up to 32 bits with a base address and length. The block holds one pending request per producer, grants them round-robin, and serialises each word into little-endian byte writes on the RAM write port. An SPI-side HOLD input stops new bursts from starting while the host reads a coherent snapshot.

---
 rtl/ram_store_scheduler_if.sv | 29 ++
 rtl/ram_store_scheduler.sv | 168 ++++++++++++++++
 tb/tb_ram_store_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_store_scheduler_if.sv
// Producer-side bus of the sensor RAM store scheduler: per-requester word posts,
// the HOLD/clear controls and the byte-wide RAM write port with status.
interface ram_store_scheduler_if #(
    parameter int NUM_REQ    = 11,
    parameter int ADDR_WIDTH = 9
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*32-1:0]         req_data;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*2-1:0]          req_len;
    logic                          hold;
    logic                          overrun_clear;
    logic                          write_en;
    logic [ADDR_WIDTH-1:0]         waddr;
    logic [7:0]                    wdata;
    logic                          busy;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            overrun;

    modport master (
        output req, req_data, req_addr, req_len, hold, overrun_clear,
        input  write_en, waddr, wdata, busy, done, overrun
    );

    modport slave (
        input  req, req_data, req_addr, req_len, hold, overrun_clear,
        output write_en, waddr, wdata, busy, done, overrun
    );
endinterface

// File: rtl/ram_store_scheduler.sv
// Round-robin arbiter that serialises posted 32-bit words into little-endian
// byte writes on the shared sensor RAM, one pending word held per requester.
module ram_store_scheduler #(
    parameter int NUM_REQ    = 11,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_store_scheduler_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        last_grant_reg, grant_reg, winner, cand;
    logic                    found, start;
    logic [31:0]             burst_data_reg;
    logic [ADDR_WIDTH-1:0]   burst_addr_reg;
    logic [1:0]              burst_len_reg, idx_reg, idx_next;

    logic                    write_en_reg, write_en_next;
    logic [ADDR_WIDTH-1:0]   waddr_reg, waddr_next;
    logic [7:0]              wdata_reg, wdata_next;
    logic                    busy_reg, busy_next;
    logic [NUM_REQ-1:0]      done_reg, done_next;

    logic [NUM_REQ-1:0]      pending_vec, overrun_vec;
    logic [31:0]             data_hold [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   addr_hold [NUM_REQ];
    logic [1:0]              len_hold  [NUM_REQ];

    // Per-requester holding registers; a re-post while still pending is an
    // overrun unless that requester is being granted on the same edge.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [31:0]           data_reg;
        logic [ADDR_WIDTH-1:0] addr_reg;
        logic [1:0]            len_reg;
        logic                  pending_reg, overrun_reg, grant_i;

        assign grant_i = start && (winner == IDX_W'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_reg    <= '0;
                addr_reg    <= '0;
                len_reg     <= '0;
                pending_reg <= 1'b0;
                overrun_reg <= 1'b0;
            end else begin
                if (bus.req[gi]) begin
                    data_reg    <= bus.req_data[32*gi +: 32];
                    addr_reg    <= bus.req_addr[ADDR_WIDTH*gi +: ADDR_WIDTH];
                    len_reg     <= bus.req_len[2*gi +: 2];
                    pending_reg <= 1'b1;
                end else if (grant_i) begin
                    pending_reg <= 1'b0;
                end
                if (bus.overrun_clear)
                    overrun_reg <= 1'b0;
                else if (bus.req[gi] && pending_reg && !grant_i)
                    overrun_reg <= 1'b1;
            end
        end

        assign pending_vec[gi] = pending_reg;
        assign overrun_vec[gi] = overrun_reg;
        assign data_hold[gi]   = data_reg;
        assign addr_hold[gi]   = addr_reg;
        assign len_hold[gi]    = len_reg;
    end

    // Scan from farthest to nearest so the requester closest after
    // last_grant is the last assignment and therefore wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
            if (pending_vec[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        start         = 1'b0;
        write_en_next = 1'b0;
        busy_next     = 1'b0;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;
        done_next     = '0;
        case (state_reg)
            IDLE: begin
                if (!bus.hold && found) begin
                    start         = 1'b1;
                    state_next    = WRITE;
                    idx_next      = 2'd0;
                    write_en_next = 1'b1;
                    busy_next     = 1'b1;
                    waddr_next    = addr_hold[winner];
                    wdata_next    = data_hold[winner][7:0];
                end
            end
            WRITE: begin
                if (idx_reg == burst_len_reg) begin
                    state_next = IDLE;
                    done_next  = NUM_REQ'(1) << grant_reg;
                end else begin
                    idx_next      = idx_reg + 2'd1;
                    write_en_next = 1'b1;
                    busy_next     = 1'b1;
                    waddr_next    = burst_addr_reg + ADDR_WIDTH'(idx_next);
                    wdata_next    = 8'(burst_data_reg >> {idx_next, 3'b000});
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            grant_reg      <= '0;
            burst_data_reg <= '0;
            burst_addr_reg <= '0;
            burst_len_reg  <= '0;
            idx_reg        <= '0;
            write_en_reg   <= 1'b0;
            waddr_reg      <= '0;
            wdata_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= '0;
        end else begin
            idx_reg      <= idx_next;
            write_en_reg <= write_en_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            if (start) begin
                last_grant_reg <= winner;
                grant_reg      <= winner;
                burst_data_reg <= data_hold[winner];
                burst_addr_reg <= addr_hold[winner];
                burst_len_reg  <= len_hold[winner];
            end
        end
    end

    assign bus.write_en = write_en_reg;
    assign bus.waddr    = waddr_reg;
    assign bus.wdata    = wdata_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.overrun  = overrun_vec;
endmodule

// File: tb/tb_ram_store_scheduler.sv
// Bench for ram_store_scheduler: a queue-based model of expected byte writes is
// compared every cycle, plus hand-computed literal checks on the logged writes.
module tb_ram_store_scheduler;
    localparam int NR = 11;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    ram_store_scheduler_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) bus();

    ram_store_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [NR-1:0] vec;
    } ev_t;

    // Model state: the remaining byte writes of the current burst, and
    // the words waiting per requester.
    wr_t           m_q[$];
    logic [NR-1:0] m_pend, m_ovr, m_done;
    logic [31:0]   m_word [NR];
    logic [AW-1:0] m_addr [NR];
    int            m_len  [NR];
    int            m_last, m_owner;

    ev_t wlog[$];
    ev_t dlog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_q.delete();
            m_pend = '0;
            m_ovr  = '0;
            m_done = '0;
            m_last = NR - 1;
            m_owner = 0;
        end else begin
            g = -1;
            m_done = '0;
            if (m_q.size() > 0) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = NR'(1) << m_owner;
            end else if (!bus.hold && m_pend != '0) begin
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (m_last + k) % NR;
                    if (m_pend[c]) begin
                        g = c;
                        break;
                    end
                end
                for (int j = 0; j <= m_len[g]; j++)
                    m_q.push_back('{addr: AW'(int'(m_addr[g]) + j), data: m_word[g][8*j +: 8]});
                m_pend[g] = 1'b0;
                m_last    = g;
                m_owner   = g;
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req[i]) begin
                    if (m_pend[i]) m_ovr[i] = 1'b1;
                    m_word[i] = bus.req_data[32*i +: 32];
                    m_addr[i] = bus.req_addr[AW*i +: AW];
                    m_len[i]  = int'(bus.req_len[2*i +: 2]);
                    m_pend[i] = 1'b1;
                end
            end
            if (bus.overrun_clear) m_ovr = '0;
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        chk("write_en", 64'(bus.write_en), 64'(m_q.size() != 0));
        chk("busy", 64'(bus.busy), 64'(m_q.size() != 0));
        chk("done", 64'(bus.done), 64'(m_done));
        chk("overrun", 64'(bus.overrun), 64'(m_ovr));
        if (m_q.size() != 0) begin
            chk("waddr", 64'(bus.waddr), 64'(m_q[0].addr));
            chk("wdata", 64'(bus.wdata), 64'(m_q[0].data));
        end
        if (bus.write_en) wlog.push_back('{cyc: cyc, addr: bus.waddr, data: bus.wdata, vec: '0});
        if (bus.done != '0) dlog.push_back('{cyc: cyc, addr: '0, data: '0, vec: bus.done});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req = '0;
            bus.overrun_clear = 1'b0;
        end
    endtask

    task automatic post(input int i, input logic [31:0] d, input logic [AW-1:0] a, input logic [1:0] l);
        bus.req[i] = 1'b1;
        bus.req_data[32*i +: 32] = d;
        bus.req_addr[AW*i +: AW] = a;
        bus.req_len[2*i +: 2]    = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        wlog.delete();
        dlog.delete();
    endtask

    task automatic chk_wr(input string name, input int j, input int c, input logic [AW-1:0] a, input logic [7:0] d);
        if (j < wlog.size()) begin
            chk({name, "_cyc"}, 64'(wlog[j].cyc), 64'(c));
            chk({name, "_addr"}, 64'(wlog[j].addr), 64'(a));
            chk({name, "_data"}, 64'(wlog[j].data), 64'(d));
        end else begin
            chk({name, "_missing"}, 64'(wlog.size()), 64'(j + 1));
        end
    endtask

    initial begin
        int c0, ch;
        bus.req = '0;
        bus.req_data = '0;
        bus.req_addr = '0;
        bus.req_len = '0;
        bus.hold = 1'b0;
        bus.overrun_clear = 1'b0;
        tick(2);
        chk("rst_write_en", 64'(bus.write_en), 64'd0);
        chk("rst_waddr", 64'(bus.waddr), 64'd0);
        chk("rst_wdata", 64'(bus.wdata), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_overrun", 64'(bus.overrun), 64'd0);
        rst = 1'b0;
        tick(1);

        // Single 4-byte request
        c0 = cyc;
        post(0, 32'hDDCCBBAA, 9'h010, 2'd3);
        tick(8);
        chk("t1_count", 64'(wlog.size()), 64'd4);
        chk_wr("t1_b0", 0, c0 + 2, 9'h010, 8'hAA);
        chk_wr("t1_b1", 1, c0 + 3, 9'h011, 8'hBB);
        chk_wr("t1_b2", 2, c0 + 4, 9'h012, 8'hCC);
        chk_wr("t1_b3", 3, c0 + 5, 9'h013, 8'hDD);
        chk("t1_done_count", 64'(dlog.size()), 64'd1);
        if (dlog.size() > 0) begin
            chk("t1_done_vec", 64'(dlog[0].vec), 64'h1);
            chk("t1_done_cyc", 64'(dlog[0].cyc), 64'(c0 + 6));
        end
        chk("t1_overrun", 64'(bus.overrun), 64'd0);

        // Round-robin, two rounds of requesters 0, 3, 5
        do_reset();
        for (int r = 0; r < 2; r++) begin
            wlog.delete();
            c0 = cyc;
            post(0, 32'h10, 9'h020, 2'd0);
            post(3, 32'h13, 9'h023, 2'd0);
            post(5, 32'h15, 9'h025, 2'd0);
            tick(10);
            chk("rr_count", 64'(wlog.size()), 64'd3);
            chk_wr("rr_g0", 0, c0 + 2, 9'h020, 8'h10);
            chk_wr("rr_g3", 1, c0 + 4, 9'h023, 8'h13);
            chk_wr("rr_g5", 2, c0 + 6, 9'h025, 8'h15);
        end

        // Overrun while requester 0 is bursting
        do_reset();
        post(0, 32'h44332211, 9'h040, 2'd3);
        tick(1);
        post(2, 32'h11, 9'h050, 2'd0);
        tick(1);
        post(2, 32'h22, 9'h050, 2'd0);
        tick(10);
        chk("ovr_count", 64'(wlog.size()), 64'd5);
        if (wlog.size() == 5) begin
            chk("ovr_addr", 64'(wlog[4].addr), 64'h050);
            chk("ovr_data", 64'(wlog[4].data), 64'h22);
        end
        chk("ovr_flag", 64'(bus.overrun), 64'h4);
        bus.overrun_clear = 1'b1;
        tick(2);
        chk("ovr_cleared", 64'(bus.overrun), 64'd0);

        // HOLD during a burst, then a request posted under HOLD
        do_reset();
        post(0, 32'hA1A2A3A4, 9'h060, 2'd3);
        tick(2);
        bus.hold = 1'b1;
        post(1, 32'h5A, 9'h070, 2'd0);
        tick(10);
        chk("hold_count", 64'(wlog.size()), 64'd4);
        chk("hold_we", 64'(bus.write_en), 64'd0);
        chk("hold_busy", 64'(bus.busy), 64'd0);
        ch = cyc;
        bus.hold = 1'b0;
        tick(6);
        chk("hold_count2", 64'(wlog.size()), 64'd5);
        chk_wr("hold_rel", 4, ch + 1, 9'h070, 8'h5A);

        // Address wrap and re-request during own burst
        do_reset();
        c0 = cyc;
        post(1, 32'h0000BEEF, 9'h1FF, 2'd1);
        tick(2);
        post(1, 32'h00001234, 9'h080, 2'd1);
        tick(10);
        chk("wrap_count", 64'(wlog.size()), 64'd4);
        chk_wr("wrap_b0", 0, c0 + 2, 9'h1FF, 8'hEF);
        chk_wr("wrap_b1", 1, c0 + 3, 9'h000, 8'hBE);
        chk_wr("wrap_r0", 2, c0 + 5, 9'h080, 8'h34);
        chk_wr("wrap_r1", 3, c0 + 6, 9'h081, 8'h12);
        chk("wrap_overrun", 64'(bus.overrun), 64'd0);
        chk("wrap_done_count", 64'(dlog.size()), 64'd2);

        // Asynchronous reset in the middle of a burst
        do_reset();
        post(0, 32'h0D0C0B0A, 9'h090, 2'd3);
        post(4, 32'h77, 9'h0A0, 2'd0);
        tick(3);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 64'(bus.write_en), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        #1 rst = 1'b0;
        tick(10);
        chk("arst_count", 64'(wlog.size()), 64'd2);
        chk("arst_done", 64'(dlog.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
